// File: rtl/pulse_stretcher_if.sv
// Event/level bundle between a pulse source and the pulse stretcher.
// The stretcher sits on the slave side; the event source is the master.
interface pulse_stretcher_if #(
   parameter int CNT_W = 8
);
   logic             din_pulse;
   logic             dout;
   logic             busy;
   logic             pending;
   logic [CNT_W-1:0] drop_cnt;

   modport master (
      output din_pulse,
      input  dout,
      input  busy,
      input  pending,
      input  drop_cnt
   );

   modport slave (
      input  din_pulse,
      output dout,
      output busy,
      output pending,
      output drop_cnt
   );
endinterface

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into fixed high levels with a forced low gap.
// Optional RETRIGGER_EN: events during the high period extend it instead of queueing.
module pulse_stretcher #(
   parameter int STRETCH = 100000,
   parameter int GAP     = 0,
   parameter int CNT_W   = 8
) (
   input logic              clk,
   input logic              rst,
   pulse_stretcher_if.slave bus
);
   localparam int MX_A = (STRETCH > GAP) ? STRETCH : GAP;
   localparam int MX   = (MX_A > 2) ? MX_A : 2;
   localparam int CW   = $clog2(MX + 1);
   localparam logic [CW-1:0] LD_H = CW'(STRETCH - 1);
   localparam logic [CW-1:0] LD_G = CW'((GAP > 0) ? GAP - 1 : 0);
   localparam logic [CNT_W-1:0] SAT = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_HIGH,
      S_GAP
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic             dout;
   logic             pending;
   logic [CNT_W-1:0] drop;
   logic             din;
   logic             last;
   logic             fin;
   logic             queue;
   logic             retrig;

   assign din  = bus.din_pulse;
   assign last = (cnt == '0);
   // fin marks the cycle where the end-of-period rule decides the next state
   assign fin  = last & ((state == S_GAP) |
                         ((state == S_HIGH) & (GAP == 0)));

`ifdef RETRIGGER_EN
   assign queue  = din & ~fin & (state == S_GAP);
   assign retrig = din & ~fin & (state == S_HIGH);
`else
   assign queue  = din & ~fin & (state != S_IDLE);
   assign retrig = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         dout    <= 1'b0;
         pending <= 1'b0;
         drop    <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (din) begin
                  state <= S_HIGH;
                  cnt   <= LD_H;
                  dout  <= 1'b1;
               end
            end
            S_HIGH: begin
               if (retrig) begin
                  cnt <= LD_H;
               end else if (!last) begin
                  cnt <= cnt - 1'b1;
               end else if (GAP > 0) begin
                  state <= S_GAP;
                  cnt   <= LD_G;
                  dout  <= 1'b0;
               end else if (pending | din) begin
                  cnt     <= LD_H;
                  pending <= pending & din;
               end else begin
                  state <= S_IDLE;
                  dout  <= 1'b0;
               end
            end
            S_GAP: begin
               if (!last) begin
                  cnt <= cnt - 1'b1;
               end else if (pending | din) begin
                  state   <= S_HIGH;
                  cnt     <= LD_H;
                  dout    <= 1'b1;
                  pending <= pending & din;
               end else begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
               dout  <= 1'b0;
            end
         endcase
         if (queue) begin
            if (!pending) begin
               pending <= 1'b1;
            end else if (drop != SAT) begin
               drop <= drop + 1'b1;
            end
         end
      end
   end

   assign bus.dout     = dout;
   assign bus.pending  = pending;
   assign bus.drop_cnt = drop;
   assign bus.busy     = (state != S_IDLE) | pending;
endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: STRETCH=4/GAP=2/CNT_W=8 and STRETCH=4/GAP=0/CNT_W=2.
// Cycle n values are observed just before posedge n, din set then is sampled at posedge n.
module tb_pulse_stretcher;
   logic clk;
   logic rst;
   int   nc;
   int   nf;

   pulse_stretcher_if #(.CNT_W(8)) bus_a ();
   pulse_stretcher_if #(.CNT_W(2)) bus_b ();

   pulse_stretcher #(
      .STRETCH(4),
      .GAP    (2),
      .CNT_W  (8)
   ) u_a (
      .clk(clk),
      .rst(rst),
      .bus(bus_a)
   );

   pulse_stretcher #(
      .STRETCH(4),
      .GAP    (0),
      .CNT_W  (2)
   ) u_b (
      .clk(clk),
      .rst(rst),
      .bus(bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit [31:0] rng(input int lo, input int hi);
      bit [31:0] r;
      r = '0;
      for (int i = lo; i <= hi; i++) r[i] = 1'b1;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nc++;
      assert (obs === exp)
      else begin
         nf++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Drives both inputs for cycles first..last and checks one instance.
   // dthr: drop count expected 1 from that cycle on (0 = stays 0).
   task automatic run(input string tag, input int first, input int last,
                      input bit [31:0] pa, input bit [31:0] pb,
                      input bit sel_b, input bit [31:0] ed,
                      input bit [31:0] eb, input bit [31:0] ep,
                      input bit chk_pd, input int dthr);
      logic od, ob, op;
      logic [7:0] odr;
      for (int n = first; n <= last; n++) begin
         bus_a.din_pulse = pa[n];
         bus_b.din_pulse = pb[n];
         if (sel_b) begin
            od  = bus_b.dout;
            ob  = bus_b.busy;
            op  = bus_b.pending;
            odr = {6'd0, bus_b.drop_cnt};
         end else begin
            od  = bus_a.dout;
            ob  = bus_a.busy;
            op  = bus_a.pending;
            odr = bus_a.drop_cnt;
         end
         chk($sformatf("%s_dout@%0d", tag, n), {31'd0, od},
             {31'd0, ed[n]});
         chk($sformatf("%s_busy@%0d", tag, n), {31'd0, ob},
             {31'd0, eb[n]});
         if (chk_pd) begin
            chk($sformatf("%s_pend@%0d", tag, n), {31'd0, op},
                {31'd0, ep[n]});
            chk($sformatf("%s_drop@%0d", tag, n), {24'd0, odr},
                (dthr > 0 && n >= dthr) ? 32'd1 : 32'd0);
         end
         @(posedge clk);
         #1;
      end
      bus_a.din_pulse = 1'b0;
      bus_b.din_pulse = 1'b0;
   endtask

   initial begin
      nc = 0;
      nf = 0;
      bus_a.din_pulse = 1'b0;
      bus_b.din_pulse = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_async_dout", {31'd0, bus_a.dout}, 32'd0);
      do_reset();
      chk("rst_a_dout", {31'd0, bus_a.dout}, 32'd0);
      chk("rst_a_busy", {31'd0, bus_a.busy}, 32'd0);
      chk("rst_a_pend", {31'd0, bus_a.pending}, 32'd0);
      chk("rst_a_drop", {24'd0, bus_a.drop_cnt}, 32'd0);
      chk("rst_b_dout", {31'd0, bus_b.dout}, 32'd0);
      chk("rst_b_drop", {30'd0, bus_b.drop_cnt}, 32'd0);

      // single pulse
      run("s1", 1, 24, rng(10, 10), '0, 1'b0,
          rng(11, 14), rng(11, 16), '0, 1'b1, 0);

      // pulses at 10 and 12
      do_reset();
`ifdef RETRIGGER_EN
      run("s4", 1, 24, rng(10, 10) | rng(12, 12), '0, 1'b0,
          rng(11, 16), rng(11, 18), '0, 1'b1, 0);
`else
      run("s2", 1, 24, rng(10, 10) | rng(12, 12), '0, 1'b0,
          rng(11, 14) | rng(17, 20), rng(11, 22), rng(13, 16), 1'b1, 0);
`endif

      // pulses at 10, 12, 13
      do_reset();
`ifdef RETRIGGER_EN
      run("s3", 1, 24, rng(10, 10) | rng(12, 13), '0, 1'b0,
          rng(11, 17), rng(11, 19), '0, 1'b1, 0);
`else
      run("s3", 1, 24, rng(10, 10) | rng(12, 13), '0, 1'b0,
          rng(11, 14) | rng(17, 20), rng(11, 22), rng(13, 16), 1'b1, 14);
`endif

`ifndef RETRIGGER_EN
      // GAP=0 instance: din high 10..16, drop counter saturates at 3
      run("s6", 1, 12, '0, rng(10, 16), 1'b1,
          rng(11, 22), rng(11, 22), '0, 1'b0, 0);
      chk("s6_pend@13", {31'd0, bus_b.pending}, 32'd1);
      chk("s6_drop@13", {30'd0, bus_b.drop_cnt}, 32'd1);
      run("s6", 13, 17, '0, rng(10, 16), 1'b1,
          rng(11, 22), rng(11, 22), '0, 1'b0, 0);
      chk("s6_drop@18", {30'd0, bus_b.drop_cnt}, 32'd3);
      run("s6", 18, 30, '0, '0, 1'b1,
          rng(11, 22), rng(11, 22), '0, 1'b0, 0);
      chk("s6_drop_hold", {30'd0, bus_b.drop_cnt}, 32'd3);
      chk("s6_pend_end", {31'd0, bus_b.pending}, 32'd0);
`endif

      // async reset in the middle of a high period
      run("s5", 1, 12, rng(10, 10), '0, 1'b0,
          rng(11, 14), rng(11, 16), '0, 1'b0, 0);
      chk("s5_pre_dout", {31'd0, bus_a.dout}, 32'd1);
      chk("s5_pre_busy", {31'd0, bus_a.busy}, 32'd1);
`ifndef RETRIGGER_EN
      chk("s5_pre_drop_a", {24'd0, bus_a.drop_cnt}, 32'd1);
      chk("s5_pre_drop_b", {30'd0, bus_b.drop_cnt}, 32'd3);
`endif
      #3;
      rst = 1'b1;
      #1;
      chk("s5_rst_dout", {31'd0, bus_a.dout}, 32'd0);
      chk("s5_rst_busy", {31'd0, bus_a.busy}, 32'd0);
      chk("s5_rst_pend", {31'd0, bus_a.pending}, 32'd0);
      chk("s5_rst_drop_a", {24'd0, bus_a.drop_cnt}, 32'd0);
      chk("s5_rst_drop_b", {30'd0, bus_b.drop_cnt}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      run("s5b", 1, 24, rng(10, 10), '0, 1'b0,
          rng(11, 14), rng(11, 16), '0, 1'b1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
      $finish;
   end
endmodule
